keypad_number_entry: RTL and testbench

- Parametrised multi-digit decimal entry accumulator for the calculator front end; generalises the fixed two-press capture to N digits.
- Consumes keypad decoder output (level-held press + 4-bit key code); builds a binary operand as value*10+digit per press, with clear, backspace and enter.
- Presents a live value for display and a valid/ack handshake for the calculator core.
- Fully clock-synchronous; press detection is edge-based, so one held key yields exactly one event.

---
 rtl/keypad_number_entry_pkg.sv | 32 +++
 rtl/keypad_number_entry_if.sv | 45 ++++
 rtl/keypad_number_entry_key_press_detect.sv | 69 ++++++
 rtl/keypad_number_entry.sv | 115 +++++++++++
 tb/tb_keypad_number_entry.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_number_entry_pkg.sv
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared key codes, entry-state encoding and parameter helpers for
//            the keypad number-entry path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    typedef enum logic [0:0] {
        ENTRY = 1'b0,
        DONE  = 1'b1
    } entry_state_e;

    // Largest decimal number representable with n digits, i.e. 10^n - 1.
    function automatic logic [63:0] max_decimal(input int unsigned n);
        logic [63:0] acc;
        acc = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc - 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_number_entry_if.sv
// ============================================================================
// Module   : keypad_number_entry_if
// Brief    : Keypad input, live operand and valid/ack handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_number_entry_if #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 32
) ();

    localparam int CW = $clog2(DIGITS + 1);

    logic             key_valid;
    logic [3:0]       key_code;
    logic [WIDTH-1:0] value;
    logic [CW-1:0]    digit_count;
    logic             full;
    logic             value_valid;
    logic             value_ack;

    modport master (
        output key_valid,
        output key_code,
        output value_ack,
        input  value,
        input  digit_count,
        input  full,
        input  value_valid
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  value_ack,
        output value,
        output digit_count,
        output full,
        output value_valid
    );

endinterface

`default_nettype wire

// File: rtl/keypad_number_entry_key_press_detect.sv
// ============================================================================
// Module   : key_press_detect
// Brief    : Optional key_valid debounce filter plus rising-edge detector;
//            filter enabled by defining KEYPAD_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_press_detect #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       key_valid,
    input  wire logic [3:0] key_code,
    output logic            press,
    output logic [3:0]      press_code
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_press_detect: DEBOUNCE_CYCLES must be at least 1");
    end

    logic w_level;
    logic r_level_q;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] r_stable_cnt;
    logic             r_filtered;

    // The filtered level follows the raw input only once it has differed for
    // DEBOUNCE_CYCLES consecutive clocks; any bounce back restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filtered   <= 1'b0;
            r_stable_cnt <= '0;
        end else if (key_valid == r_filtered) begin
            r_stable_cnt <= '0;
        end else if (r_stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_filtered   <= key_valid;
            r_stable_cnt <= '0;
        end else begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
        end
    end

    assign w_level = r_filtered;
`else
    assign w_level = key_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= w_level;
        end
    end

    // Code is taken in the same cycle as the pulse so the consumer updates
    // on the following edge.
    assign press      = w_level & ~r_level_q;
    assign press_code = key_code;

endmodule

`default_nettype wire

// File: rtl/keypad_number_entry.sv
// ============================================================================
// Module   : keypad_number_entry
// Brief    : N-digit decimal operand accumulator with clear/backspace/enter
//            and valid/ack handoff; KEYPAD_DEBOUNCE_EN adds input debounce.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_number_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    keypad_number_entry_if.slave   bus
);

    localparam int CW = $clog2(DIGITS + 1);

    localparam logic [0:0] ST_ENTRY = ENTRY;
    localparam logic [0:0] ST_DONE  = DONE;

    if ((WIDTH < 64) && (max_decimal(DIGITS) > ((64'd1 << WIDTH) - 64'd1))) begin : g_width_check
        $error("keypad_number_entry: WIDTH too small to hold DIGITS decimal digits");
    end

    logic             w_press;
    logic [3:0]       w_code;
    logic             w_is_digit;
    logic [WIDTH-1:0] w_times10;
    logic [WIDTH-1:0] w_div10;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_value;
    logic [CW-1:0]    r_count;
    logic             r_valid;

    key_press_detect #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_press (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (bus.key_valid),
        .key_code   (bus.key_code),
        .press      (w_press),
        .press_code (w_code)
    );

    assign w_is_digit = (w_code <= 4'd9);
    assign w_times10  = (r_value << 3) + (r_value << 1) + WIDTH'(w_code);
    assign w_div10    = r_value / WIDTH'(10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ENTRY;
            r_value <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (w_press) begin
                        if (w_is_digit) begin
                            if (r_count < CW'(DIGITS)) begin
                                r_value <= w_times10;
                                r_count <= r_count + 1'b1;
                            end
                        end else begin
                            case (w_code)
                                KEY_CLEAR: begin
                                    r_value <= '0;
                                    r_count <= '0;
                                end
                                KEY_BKSP: begin
                                    if (r_count != '0) begin
                                        r_value <= w_div10;
                                        r_count <= r_count - 1'b1;
                                    end
                                end
                                KEY_ENTER: begin
                                    if (r_count != '0) begin
                                        r_valid <= 1'b1;
                                        r_state <= ST_DONE;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_DONE: begin
                    // Presses here are dropped, even one coinciding with ack.
                    if (bus.value_ack) begin
                        r_valid <= 1'b0;
                        r_value <= '0;
                        r_count <= '0;
                        r_state <= ST_ENTRY;
                    end
                end
                default: r_state <= ST_ENTRY;
            endcase
        end
    end

    assign bus.value       = r_value;
    assign bus.digit_count = r_count;
    assign bus.full        = (r_count == CW'(DIGITS));
    assign bus.value_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_keypad_number_entry.sv
// ============================================================================
// Module   : tb_keypad_number_entry
// Brief    : Table-driven scoreboard bench for keypad_number_entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_number_entry;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 32;
    localparam int DEB    = 8;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int LAT    = DEB + 1;
`else
    localparam int LAT    = 1;
`endif
    localparam int HOLD   = LAT + 2;

    typedef struct {
        longint val;
        int     cnt;
        bit     full;
        bit     vv;
    } exp_t;

    typedef struct {
        bit         is_ack;
        logic [3:0] code;
        exp_t       exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    keypad_number_entry_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

    keypad_number_entry #(
        .DIGITS          (DIGITS),
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t e(longint val, int cnt, bit full, bit vv);
        exp_t r;
        r.val = val; r.cnt = cnt; r.full = full; r.vv = vv;
        return r;
    endfunction

    function automatic vec_t v(bit is_ack, logic [3:0] code, exp_t ex);
        vec_t r;
        r.is_ack = is_ack; r.code = code; r.exp = ex;
        return r;
    endfunction

    task automatic chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_outputs(string tag, exp_t ex);
        chk({tag, " value"}, longint'(bus.value), ex.val);
        chk({tag, " digit_count"}, longint'(bus.digit_count), longint'(ex.cnt));
        chk({tag, " full"}, longint'(bus.full), longint'(ex.full));
        chk({tag, " value_valid"}, longint'(bus.value_valid), longint'(ex.vv));
    endtask

    task automatic check_sb(string tag);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty actual=0 required=1", tag);
        end else begin
            check_outputs(tag, sb.pop_front());
        end
    endtask

    // Press, compare after the press latency, hold, release and idle.
    task automatic do_press(string tag, logic [3:0] code, exp_t ex);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        sb.push_back(ex);
        repeat (LAT) @(posedge clk);
        #1;
        check_sb(tag);
        repeat (HOLD - LAT) @(posedge clk);
        @(negedge clk);
        bus.key_valid = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic do_ack(string tag, exp_t ex);
        @(negedge clk);
        bus.value_ack = 1'b1;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        check_sb(tag);
        @(negedge clk);
        bus.value_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.value_ack = 1'b0;

        tbl.push_back(v(0, 4'h1, e(1, 1, 0, 0)));
        tbl.push_back(v(0, 4'h2, e(12, 2, 0, 0)));
        tbl.push_back(v(0, 4'h3, e(123, 3, 0, 0)));
        tbl.push_back(v(0, 4'hC, e(123, 3, 0, 1)));
        tbl.push_back(v(1, 4'h0, e(0, 0, 0, 0)));
        tbl.push_back(v(0, 4'h1, e(1, 1, 0, 0)));
        tbl.push_back(v(0, 4'h2, e(12, 2, 0, 0)));
        tbl.push_back(v(0, 4'h3, e(123, 3, 0, 0)));
        tbl.push_back(v(0, 4'h4, e(1234, 4, 1, 0)));
        tbl.push_back(v(0, 4'h5, e(1234, 4, 1, 0)));
        tbl.push_back(v(0, 4'hA, e(0, 0, 0, 0)));
        tbl.push_back(v(0, 4'hB, e(0, 0, 0, 0)));
        tbl.push_back(v(0, 4'h9, e(9, 1, 0, 0)));
        tbl.push_back(v(0, 4'h8, e(98, 2, 0, 0)));
        tbl.push_back(v(0, 4'h7, e(987, 3, 0, 0)));
        tbl.push_back(v(0, 4'hB, e(98, 2, 0, 0)));
        tbl.push_back(v(0, 4'hB, e(9, 1, 0, 0)));
        tbl.push_back(v(0, 4'h6, e(96, 2, 0, 0)));
        tbl.push_back(v(0, 4'hA, e(0, 0, 0, 0)));
        tbl.push_back(v(0, 4'hC, e(0, 0, 0, 0)));
        tbl.push_back(v(0, 4'h0, e(0, 1, 0, 0)));
        tbl.push_back(v(0, 4'h0, e(0, 2, 0, 0)));
        tbl.push_back(v(0, 4'h7, e(7, 3, 0, 0)));
        tbl.push_back(v(1, 4'h0, e(7, 3, 0, 0)));
        tbl.push_back(v(0, 4'hA, e(0, 0, 0, 0)));
        tbl.push_back(v(0, 4'h4, e(4, 1, 0, 0)));
        tbl.push_back(v(0, 4'h2, e(42, 2, 0, 0)));
        tbl.push_back(v(0, 4'hA, e(0, 0, 0, 0)));
        tbl.push_back(v(0, 4'hE, e(0, 0, 0, 0)));
        tbl.push_back(v(0, 4'h7, e(7, 1, 0, 0)));
        tbl.push_back(v(0, 4'hC, e(7, 1, 0, 1)));
        tbl.push_back(v(0, 4'h3, e(7, 1, 0, 1)));
        tbl.push_back(v(0, 4'hA, e(7, 1, 0, 1)));

        repeat (3) @(negedge clk);
        #1;
        check_outputs("reset", e(0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_ack)
                do_ack($sformatf("vec%0d", i), tbl[i].exp);
            else
                do_press($sformatf("vec%0d", i), tbl[i].code, tbl[i].exp);
        end

        // Press of 8 coinciding with ack in DONE: ack wins, the 8 is lost.
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h8;
        repeat (LAT - 1) @(negedge clk);
        bus.value_ack = 1'b1;
        sb.push_back(e(0, 0, 0, 0));
        @(posedge clk);
        #1;
        check_sb("ack_with_press");
        @(negedge clk);
        bus.value_ack = 1'b0;
        repeat (HOLD + 5) @(negedge clk);
        check_outputs("held_no_replay", e(0, 0, 0, 0));
        bus.key_valid = 1'b0;
        repeat (HOLD) @(negedge clk);
        do_press("repress8", 4'h8, e(8, 1, 0, 0));

        // A long hold yields exactly one digit.
        do_press("clr_hold", 4'hA, e(0, 0, 0, 0));
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h5;
        repeat (20) @(negedge clk);
        check_outputs("hold20", e(5, 1, 0, 0));
        bus.key_valid = 1'b0;
        repeat (HOLD) @(negedge clk);

`ifdef KEYPAD_DEBOUNCE_EN
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h3;
        repeat (3) @(negedge clk);
        bus.key_valid = 1'b0;
        repeat (DEB + 4) @(negedge clk);
        check_outputs("glitch3", e(5, 1, 0, 0));
`endif

        do_press("clr_rst", 4'hA, e(0, 0, 0, 0));
        do_press("p5", 4'h5, e(5, 1, 0, 0));
        do_press("p56", 4'h6, e(56, 2, 0, 0));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", e(0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_press("after_reset", 4'h3, e(3, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
